// File: rtl/pattern_scheduler.sv
// pattern_scheduler: picks one of NUM_PATTERNS RGB sources, advancing on frame dwell or a debounced button.
// Define PATTERN_SCHED_FADE_EN to fade out/in across switches; otherwise each switch is a hard cut.
module pattern_scheduler #(
  parameter int unsigned NUM_PATTERNS    = 3,
  parameter int unsigned DWELL_FRAMES    = 600,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       frame,
  input  logic                              btn_next,
  input  logic                              btn_hold,
  input  logic [12*NUM_PATTERNS-1:0]        pix_in,
  output logic [$clog2(NUM_PATTERNS)-1:0]   sel,
  output logic [NUM_PATTERNS-1:0]           pattern_rst,
  output logic [3:0]                        r,
  output logic [3:0]                        g,
  output logic [3:0]                        b
);

  localparam int unsigned SW  = $clog2(NUM_PATTERNS);
  localparam int unsigned DWW = $clog2(DWELL_FRAMES + 1);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef PATTERN_SCHED_FADE_EN
  typedef enum logic [1:0] {SHOW, FADE_OUT, SWITCH, FADE_IN} state_t;
  logic [4:0] level, level_n;
`else
  typedef enum logic [0:0] {SHOW, SWITCH} state_t;
`endif

  state_t                  state, state_n;
  logic [DWW-1:0]          dwell, dwell_n;
  logic [SW-1:0]           sel_n, sel_inc;
  logic [NUM_PATTERNS-1:0] prst_n;
  logic [31:0]             frame_prev;
  logic [1:0]              next_sync, hold_sync;
  logic                    next_db, adv_req;
  logic [DBW-1:0]          db_cnt;
  logic                    tick, hold;
  logic [11:0]             src;

  assign tick = (frame != frame_prev);
  assign hold = hold_sync[1];
  assign src  = pix_in[12*sel +: 12];

  // Synchronisers, btn_next debounce and rising-edge advance request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_sync <= '0;
      hold_sync <= '0;
      next_db   <= 1'b0;
      db_cnt    <= '0;
      adv_req   <= 1'b0;
    end else begin
      next_sync <= {next_sync[0], btn_next};
      hold_sync <= {hold_sync[0], btn_hold};
      adv_req   <= 1'b0;
      if (next_sync[1] == next_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt  <= '0;
        next_db <= next_sync[1];
        adv_req <= next_sync[1];
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  always_comb begin
    sel_inc = (sel == SW'(NUM_PATTERNS - 1)) ? '0 : sel + SW'(1);
  end

  // Next-state logic; sel and the reset pulse update on entry to SWITCH
  always_comb begin
    state_n = state;
    dwell_n = dwell;
    sel_n   = sel;
    prst_n  = '0;
`ifdef PATTERN_SCHED_FADE_EN
    level_n = level;
`endif
    case (state)
      SHOW: begin
        if (tick && !hold) dwell_n = dwell + DWW'(1);
        if (adv_req || (tick && !hold && dwell == DWW'(DWELL_FRAMES - 1))) begin
          dwell_n = '0;
`ifdef PATTERN_SCHED_FADE_EN
          state_n = FADE_OUT;
`else
          state_n = SWITCH;
          sel_n   = sel_inc;
          prst_n  = NUM_PATTERNS'(1) << sel_inc;
`endif
        end
      end
`ifdef PATTERN_SCHED_FADE_EN
      FADE_OUT: begin
        if (tick) begin
          level_n = level - 5'd1;
          if (level == 5'd1) begin
            state_n = SWITCH;
            sel_n   = sel_inc;
            prst_n  = NUM_PATTERNS'(1) << sel_inc;
          end
        end
      end
      SWITCH: state_n = FADE_IN;
      FADE_IN: begin
        if (tick) begin
          level_n = level + 5'd1;
          if (level == 5'd15) state_n = SHOW;
        end
      end
`else
      SWITCH: state_n = SHOW;
`endif
      default: state_n = SHOW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SHOW;
      dwell       <= '0;
      sel         <= '0;
      pattern_rst <= '0;
      frame_prev  <= '0;
`ifdef PATTERN_SCHED_FADE_EN
      level       <= 5'd16;
`endif
    end else begin
      state       <= state_n;
      dwell       <= dwell_n;
      sel         <= sel_n;
      pattern_rst <= prst_n;
      frame_prev  <= frame;
`ifdef PATTERN_SCHED_FADE_EN
      level       <= level_n;
`endif
    end
  end

`ifdef PATTERN_SCHED_FADE_EN
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
    return 4'((9'(c) * 9'(lvl)) >> 4);
  endfunction
`endif

  // Colour output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
`ifdef PATTERN_SCHED_FADE_EN
      r <= scale(src[11:8], level);
      g <= scale(src[7:4], level);
      b <= scale(src[3:0], level);
`else
      {r, g, b} <= src;
`endif
    end
  end

endmodule
